// File: rtl/user_obi_copier.sv
// OBI word copier: read src, write dst, one outstanding access; fill mode behind USER_OBI_COPIER_FILL_EN.
// Latency 4 cycles/word at zero wait; stalls on gnt_i low and waits on rvalid_i, start_i ignored while busy.
module user_obi_copier #(
    parameter int unsigned LenWidth = 16,
    parameter int unsigned IdWidth  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
    input  logic                fill_i,
    input  logic [31:0]         fill_pattern_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic                req_o,
    input  logic                gnt_i,
    output logic [31:0]         addr_o,
    output logic                we_o,
    output logic [3:0]          be_o,
    output logic [31:0]         wdata_o,
    output logic [IdWidth-1:0]  aid_o,
    input  logic                rvalid_i,
    input  logic [31:0]         rdata_i,
    input  logic                err_i,
    input  logic [IdWidth-1:0]  rid_i
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

    state_e              state_q, state_d;
    logic [31:0]         src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [LenWidth-1:0] len_q, len_d, cnt_q, cnt_d;
    logic                fill_q, fill_d, zdone_q, zdone_d, err_q, err_d;
    logic                done_now;
    logic                fill_sel;
    logic [31:0]         fill_word;

`ifdef USER_OBI_COPIER_FILL_EN
    assign fill_sel  = fill_i;
    assign fill_word = fill_pattern_i;
    logic unused_rid;
    assign unused_rid = ^rid_i;
`else
    assign fill_sel  = 1'b0;
    assign fill_word = 32'h0;
    logic unused_in;
    assign unused_in = ^{fill_i, fill_pattern_i, rid_i};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            buf_q   <= 32'h0;
            len_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            zdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            zdone_q <= zdone_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        buf_d    = buf_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        zdone_d  = 1'b0;
        err_d    = err_q;
        done_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d  = {src_addr_i[31:2], 2'b00};
                    dst_d  = {dst_addr_i[31:2], 2'b00};
                    len_d  = len_i;
                    fill_d = fill_sel;
                    cnt_d  = '0;
                    if (len_i == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (fill_sel) begin
                            buf_d   = fill_word;
                            state_d = WR_REQ;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: if (gnt_i) state_d = RD_WAIT;
            RD_WAIT: begin
                if (rvalid_i) begin
                    if (err_i) begin
                        err_d    = 1'b1;
                        done_now = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        buf_d   = rdata_i;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: if (gnt_i) state_d = WR_WAIT;
            WR_WAIT: begin
                if (rvalid_i) begin
                    if (err_i) begin
                        err_d    = 1'b1;
                        done_now = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        // Addresses wrap naturally at 2^32.
                        cnt_d = cnt_q + LenWidth'(1);
                        src_d = src_q + 32'd4;
                        dst_d = dst_q + 32'd4;
                        if (cnt_d == len_q) begin
                            done_now = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = fill_q ? WR_REQ : RD_REQ;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion is flagged in the final response cycle; zero-length starts finish one cycle later.
    assign done_o  = zdone_q | done_now;
    assign busy_o  = (state_q != IDLE);
    assign error_o = err_q;
    assign req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign we_o    = (state_q == WR_REQ);
    assign addr_o  = (state_q == WR_REQ) ? dst_q : src_q;
    assign be_o    = 4'hF;
    assign wdata_o = buf_q;
    assign aid_o   = '0;

endmodule

// File: tb/tb_user_obi_copier.sv
// Bench for user_obi_copier: zero-wait OBI subordinate with stall/error injection and a
// transaction-list reference model derived from the copy/fill rules.
module tb_user_obi_copier;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [0:0]  aid;
    } txn_t;

`ifdef USER_OBI_COPIER_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, fill_i;
    logic [31:0] src_addr_i, dst_addr_i, fill_pattern_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, error_o, req_o, we_o;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic [0:0]  aid_o, rid_i;
    logic        gnt_i, rvalid_i, err_i;
    logic [31:0] rdata_i;

    int          n_checks = 0;
    int          n_errors = 0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] seed       = 32'h0;
    logic [31:0] err_addr   = 32'h1;
    logic [31:0] stall_addr = 32'h1;
    int          stall_len  = 0;
    bit          rand_stall = 1'b0;

    user_obi_copier dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .fill_i(fill_i), .fill_pattern_i(fill_pattern_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
        .wdata_o(wdata_o), .aid_o(aid_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i), .rid_i(rid_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ seed;
    endfunction

    // Subordinate: grant decision after each rising edge, handshake sampled mid-cycle,
    // response returned in the following cycle.
    always begin : subordinate
        bit          pend      = 1'b0;
        bit          pend_err  = 1'b0;
        logic [31:0] pend_data = 32'h0;
        int          stall_run = 0;
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            gnt_i = 1'b1; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
            pend = 1'b0; pend_err = 1'b0; stall_run = 0;
        end else begin
            rvalid_i = pend; err_i = pend_err; rdata_i = pend_data;
            pend = 1'b0; pend_err = 1'b0;
            if (req_o && we_o && addr_o == stall_addr && stall_run < stall_len) begin
                gnt_i = 1'b0;
                stall_run++;
            end else begin
                if (!(req_o && we_o && addr_o == stall_addr)) stall_run = 0;
                gnt_i = !(rand_stall && $urandom_range(0, 2) == 0);
            end
        end
        @(negedge clk_i);
        if (!rst_i && req_o && gnt_i) begin
            log_q.push_back('{we: we_o, addr: addr_o, data: (we_o ? wdata_o : 32'h0), be: be_o, aid: aid_o});
            pend      = 1'b1;
            pend_data = we_o ? 32'h0 : rd_word(addr_o);
            pend_err  = !we_o && (addr_o == err_addr);
        end
    end

    // Expected OBI traffic: per word a read of src then a write of that word to dst
    // (fill: writes of the pattern only); an erroring read ends the list.
    function automatic void build_exp(input logic [31:0] src, input logic [31:0] dst, input int len,
                                      input bit fill, input logic [31:0] pat, input int err_rd);
        logic [31:0] s, d;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            if (!fill) begin
                exp_q.push_back('{we: 1'b0, addr: s, data: 32'h0, be: 4'hF, aid: 1'b0});
                if (err_rd == i + 1) return;
            end
            exp_q.push_back('{we: 1'b1, addr: d, data: (fill ? pat : rd_word(s)), be: 4'hF, aid: 1'b0});
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endfunction

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int len,
                            input bit f, input logic [31:0] pat);
        @(posedge clk_i);
        #1;
        src_addr_i = s; dst_addr_i = d; len_i = 16'(len);
        fill_i = f; fill_pattern_i = pat; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0; fill_i = 1'b0;
    endtask

    // Watches a fixed window; lat is the first cycle (start cycle = 0) with done_o, -1 if none.
    task automatic wait_done(output int lat, output int pulses, input int window);
        lat = -1;
        pulses = 0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic test_reset;
        logic [73:0] got_v;
        logic [73:0] exp_v;
        exp_v = {2'b00, 64'h0, 4'hF, 1'b0, 3'b000};
        repeat (2) @(negedge clk_i);
        got_v = {req_o, we_o, addr_o, wdata_o, be_o, aid_o, busy_o, done_o, error_o};
        n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL reset_outputs: got %h expected %h", got_v, exp_v); end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        got_v = {req_o, we_o, addr_o, wdata_o, be_o, aid_o, busy_o, done_o, error_o};
        n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL idle_after_reset: got %h expected %h", got_v, exp_v); end
    endtask

    task automatic test_copy;
        int base, lat, p;
        txn_t got;
        seed = $urandom;
        base = log_q.size();
        do_start(32'h2000_0000, 32'h1000_0100, 3, 1'b0, 32'h0);
        wait_done(lat, p, 20);
        n_checks++;
        if (lat != 12) begin n_errors++; $display("FAIL copy_latency: got %0d expected 12", lat); end
        n_checks++;
        if (p != 1) begin n_errors++; $display("FAIL copy_done_pulses: got %0d expected 1", p); end
        n_checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin n_errors++; $display("FAIL copy_status: error=%b busy=%b expected 0 0", error_o, busy_o); end
        build_exp(32'h2000_0000, 32'h1000_0100, 3, 1'b0, 32'h0, 0);
        n_checks++;
        if (log_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL copy_count: got %0d expected %0d", log_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin n_errors++; $display("FAIL copy_txn%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_gnt_stall;
        logic [64:0] held, cur;
        int n, got_done;
        seed = $urandom;
        stall_addr = 32'h1000_0100;
        stall_len  = 5;
        n = 0;
        got_done = 0;
        held = '0;
        do_start(32'h2000_0000, 32'h1000_0100, 1, 1'b0, 32'h0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (done_o) got_done++;
            if (req_o && we_o) begin
                cur = {we_o, addr_o, wdata_o};
                if (n == 0) held = {1'b1, 32'h1000_0100, rd_word(32'h2000_0000)};
                n++;
                n_checks++;
                if (cur !== held) begin n_errors++; $display("FAIL stall_hold_cyc%0d: got %h expected %h", n, cur, held); end
            end
        end
        stall_len  = 0;
        stall_addr = 32'h1;
        n_checks++;
        if (n != 6) begin n_errors++; $display("FAIL stall_req_cycles: got %0d expected 6", n); end
        n_checks++;
        if (got_done != 1) begin n_errors++; $display("FAIL stall_done: got %0d expected 1", got_done); end
    endtask

    task automatic test_error;
        int base, lat, p, req_seen;
        txn_t got;
        seed = $urandom;
        base = log_q.size();
        err_addr = 32'h2000_0104;
        do_start(32'h2000_0100, 32'h1000_0200, 4, 1'b0, 32'h0);
        wait_done(lat, p, 30);
        err_addr = 32'h1;
        n_checks++;
        if (lat != 6 || p != 1) begin n_errors++; $display("FAIL err_done: got lat=%0d pulses=%0d expected 6 1", lat, p); end
        n_checks++;
        if (error_o !== 1'b1) begin n_errors++; $display("FAIL err_flag: got %b expected 1", error_o); end
        req_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (req_o !== 1'b0) req_seen++;
        end
        n_checks++;
        if (req_seen != 0) begin n_errors++; $display("FAIL err_req_quiet: got %0d req cycles expected 0", req_seen); end
        build_exp(32'h2000_0100, 32'h1000_0200, 4, 1'b0, 32'h0, 2);
        n_checks++;
        if (log_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL err_count: got %0d expected %0d", log_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin n_errors++; $display("FAIL err_txn%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_len0_unaligned;
        int base, lat, p;
        txn_t got;
        seed = $urandom;
        base = log_q.size();
        do_start(32'h2000_0003, 32'h1000_0102, 0, 1'b0, 32'h0);
        wait_done(lat, p, 6);
        n_checks++;
        if (lat != 1 || p != 1) begin n_errors++; $display("FAIL len0_done: got lat=%0d pulses=%0d expected 1 1", lat, p); end
        n_checks++;
        if (log_q.size() != base) begin n_errors++; $display("FAIL len0_traffic: got %0d txns expected 0", log_q.size() - base); end
        n_checks++;
        if (error_o !== 1'b1) begin n_errors++; $display("FAIL len0_error_kept: got %b expected 1", error_o); end
        do_start(32'h2000_0003, 32'h1000_0102, 1, 1'b0, 32'h0);
        wait_done(lat, p, 10);
        n_checks++;
        if (lat != 4 || p != 1) begin n_errors++; $display("FAIL unal_done: got lat=%0d pulses=%0d expected 4 1", lat, p); end
        n_checks++;
        if (error_o !== 1'b0) begin n_errors++; $display("FAIL unal_error_clr: got %b expected 0", error_o); end
        build_exp(32'h2000_0003, 32'h1000_0102, 1, 1'b0, 32'h0, 0);
        n_checks++;
        if (log_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL unal_count: got %0d expected %0d", log_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin n_errors++; $display("FAIL unal_txn%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_fill;
        int base, lat, p, exp_lat;
        txn_t got;
        seed = $urandom;
        base = log_q.size();
        exp_lat = FillEn ? 4 : 8;
        do_start(32'h4000_0000, 32'hFFFF_FFFC, 2, 1'b1, 32'hDEAD_BEEF);
        wait_done(lat, p, 20);
        n_checks++;
        if (lat != exp_lat || p != 1) begin n_errors++; $display("FAIL fill_done: got lat=%0d pulses=%0d expected %0d 1", lat, p, exp_lat); end
        build_exp(32'h4000_0000, 32'hFFFF_FFFC, 2, FillEn, 32'hDEAD_BEEF, 0);
        n_checks++;
        if (log_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", log_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin n_errors++; $display("FAIL fill_txn%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_abort;
        int base, lat, p, found, dones;
        logic [73:0] got_v;
        txn_t got;
        seed = $urandom;
        base = log_q.size();
        found = 0;
        do_start(32'h2000_0040, 32'h1000_0040, 3, 1'b0, 32'h0);
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk_i);
            if (req_o && !we_o && gnt_i) found = 1;
        end
        n_checks++;
        if (found == 0) begin n_errors++; $display("FAIL abort_read_req: got none expected a read request"); end
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        got_v = {req_o, we_o, addr_o, wdata_o, be_o, aid_o, busy_o, done_o, error_o};
        n_checks++;
        if (got_v !== {2'b00, 64'h0, 4'hF, 1'b0, 3'b000}) begin n_errors++; $display("FAIL abort_outputs: got %h expected %h", got_v, {2'b00, 64'h0, 4'hF, 1'b0, 3'b000}); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (done_o || busy_o) dones++;
        end
        n_checks++;
        if (dones != 0 || log_q.size() != base + 1) begin n_errors++; $display("FAIL abort_quiet: got %0d done/busy cycles %0d txns expected 0 1", dones, log_q.size() - base); end
        base = log_q.size();
        do_start(32'h2000_0080, 32'h1000_0080, 2, 1'b0, 32'h0);
        wait_done(lat, p, 20);
        n_checks++;
        if (lat != 8 || p != 1) begin n_errors++; $display("FAIL abort_rerun_done: got lat=%0d pulses=%0d expected 8 1", lat, p); end
        build_exp(32'h2000_0080, 32'h1000_0080, 2, 1'b0, 32'h0, 0);
        foreach (exp_q[i]) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin n_errors++; $display("FAIL abort_rerun_txn%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_busy_start_ignored;
        int base, lat, p;
        txn_t got;
        seed = $urandom;
        base = log_q.size();
        do_start(32'h2000_0200, 32'h1000_0300, 2, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        src_addr_i = 32'h5000_0000; dst_addr_i = 32'h5100_0000; len_i = 16'd1; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(lat, p, 20);
        n_checks++;
        if (p != 1) begin n_errors++; $display("FAIL busy_start_pulses: got %0d expected 1", p); end
        build_exp(32'h2000_0200, 32'h1000_0300, 2, 1'b0, 32'h0, 0);
        n_checks++;
        if (log_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL busy_start_count: got %0d expected %0d", log_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin n_errors++; $display("FAIL busy_start_txn%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_random;
        int base, lat, p, len;
        logic [31:0] s, d;
        txn_t got;
        rand_stall = 1'b1;
        for (int it = 0; it < 6; it++) begin
            seed = $urandom;
            len  = $urandom_range(1, 6);
            s    = 32'h2000_0000 + (32'($urandom_range(0, 255)) << 6) + 32'($urandom_range(0, 3));
            d    = 32'h6000_0000 + (32'($urandom_range(0, 255)) << 6) + 32'($urandom_range(0, 3));
            base = log_q.size();
            do_start(s, d, len, 1'b0, 32'h0);
            wait_done(lat, p, len * 16 + 20);
            n_checks++;
            if (p != 1 || error_o !== 1'b0) begin n_errors++; $display("FAIL rand%0d_done: got pulses=%0d error=%b expected 1 0", it, p, error_o); end
            build_exp(s, d, len, 1'b0, 32'h0, 0);
            n_checks++;
            if (log_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, log_q.size() - base, exp_q.size()); end
            foreach (exp_q[i]) begin
                got = (base + i < log_q.size()) ? log_q[base + i] : '0;
                n_checks++;
                if (got !== exp_q[i]) begin n_errors++; $display("FAIL rand%0d_txn%0d: got %h expected %h", it, i, got, exp_q[i]); end
            end
        end
        rand_stall = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0; fill_i = 1'b0;
        src_addr_i = 32'h0; dst_addr_i = 32'h0; len_i = 16'h0;
        fill_pattern_i = 32'h0; rid_i = 1'b0;
        test_reset();
        test_copy();
        test_gnt_stall();
        test_error();
        test_len0_unaligned();
        test_fill();
        test_reset_abort();
        test_busy_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/user_obi_copier.md
USER_OBI_COPIER -- requirements
Module: user_obi_copier

Interface
REQ-001 SHALL have parameter LenWidth, default 16, word-count width of len_i.
REQ-002 SHALL have parameter IdWidth, default 1, width of aid_o/rid_i.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports start_i input 1 (one-cycle start pulse), src_addr_i input 32, dst_addr_i input 32, len_i input LenWidth (words to move).
REQ-006 SHALL have ports fill_i input 1 (fill mode select) and fill_pattern_i input 32 (fill word).
REQ-007 SHALL have ports busy_o output 1, done_o output 1 (one-cycle pulse), error_o output 1 (sticky).
REQ-008 SHALL have OBI manager ports req_o output 1, gnt_i input 1, addr_o output 32, we_o output 1, be_o output 4, wdata_o output 32, aid_o output IdWidth.
REQ-009 SHALL have OBI response ports rvalid_i input 1, rdata_i input 32, err_i input 1, rid_i input IdWidth (rid_i unused, single outstanding).

Function
REQ-010 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-011 SHALL in IDLE latch src/dst with bits [1:0] forced to 0, len and fill on start_i; len_i==0 -> done_o pulse next cycle, no bus traffic, stay IDLE.
REQ-012 SHALL on start with len>0 clear error_o and enter RD_REQ (fill mode: WR_REQ).
REQ-013 SHALL assert req_o only in RD_REQ/WR_REQ; addr_o, we_o, be_o, wdata_o held stable while req_o high and gnt_i low.
REQ-014 SHALL drive be_o=4'hF, aid_o='0; we_o=0 in RD_REQ, 1 in WR_REQ; wdata_o = word buffer.
REQ-015 SHALL move RD_REQ->RD_WAIT and WR_REQ->WR_WAIT on the cycle req_o&&gnt_i.
REQ-016 SHALL in RD_WAIT on rvalid_i&&!err_i capture rdata_i into word buffer, go WR_REQ.
REQ-017 SHALL in WR_WAIT on rvalid_i&&!err_i increment word count and both addresses by 4 (modulo 2^32 wrap), then IDLE with done_o pulse if count==len else RD_REQ.
REQ-018 SHALL on rvalid_i&&err_i in either WAIT state set error_o, pulse done_o, return to IDLE, no further requests.
REQ-019 SHALL ignore rvalid_i outside WAIT states and start_i while busy_o.
REQ-020 SHALL assert busy_o in every state except IDLE.
REQ-021 SHALL take minimum 4 cycles per copied word with zero-wait gnt and next-cycle rvalid.
REQ-022 SHALL treat len counter as LenWidth bits; max transfer 2^LenWidth-1 words.

Reset
REQ-023 SHALL on rst_i asynchronously enter IDLE with req_o=0, we_o=0, addr_o=0, wdata_o=0, be_o=4'hF, aid_o=0, busy_o=0, done_o=0, error_o=0, counters/buffers 0.
REQ-024 SHALL abort mid-transfer on rst_i without completing an outstanding OBI transaction and without a done_o pulse.

Configuration
REQ-025 SHALL with USER_OBI_COPIER_FILL_EN defined honour fill_i: skip read phase, wdata_o=fill_pattern_i each word, WR_WAIT loops to WR_REQ.
REQ-026 SHALL without USER_OBI_COPIER_FILL_EN ignore fill_i and fill_pattern_i; always copy.

Verification
REQ-027 SHALL cover copy: src=0x2000_0000, dst=0x1000_0100, len=3, zero-wait subordinate -> 3 reads then writes interleaved, dst words equal src, done_o at cycle 12 after start.
REQ-028 SHALL cover gnt stall: gnt_i low 5 cycles on first write -> addr_o=0x1000_0100, wdata_o, we_o=1 stable all 6 cycles.
REQ-029 SHALL cover error: err_i on second read of len=4 -> error_o=1, done_o one pulse, one write completed, req_o stays 0.
REQ-030 SHALL cover len=0 and unaligned src=0x2000_0003 -> done_o next cycle no traffic; aligned run reads 0x2000_0000.
REQ-031 SHALL cover fill (macro on): fill_pattern_i=0xDEAD_BEEF, len=2, dst=0xFFFF_FFFC -> writes to 0xFFFF_FFFC and 0x0000_0000, no reads; macro off: same stimulus performs copy.
REQ-032 SHALL cover rst_i asserted in RD_WAIT -> all outputs at reset values same cycle, next start runs normally.
